window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Streaming 3x3 neighbourhood generator, directly upstream of the gradient/edge stage.
//  Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers the two
//  previous image lines. For every interior pixel it emits a packed 9-pixel window that
//  the gradient stage consumes without any reformatting.
// PARAMETERS
//  inputWidth  8    bits per pixel
//  IMG_WIDTH   640  pixels per line (>=3); sets line-buffer depth
//  IMG_HEIGHT  480  lines per frame (>=3)
// PORTS
//  clk           in   1              sole clock; all state updates on rising edge
//  rst           in   1              synchronous, active-high reset
//  pixel_in      in   inputWidth     incoming pixel, raster order
//  pixel_valid   in   1              pixel_in is accepted this cycle; low = stall, no loss
//  sof           in   1              start of frame; qualified by pixel_valid; marks pixel (0,0)
//  window_out    out  9*inputWidth   win[i] = window_out[i*inputWidth+inputWidth-1 : i*inputWidth]
//  window_valid  out  1              window_out holds a new window this cycle (one-cycle pulse)
//  center_col    out  16             column of the window centre pixel (win[4])
//  center_row    out  16             row of the window centre pixel (win[4])
// BEHAVIOUR
//  - Window layout is row-major: [0][1][2] / [3][4][5] / [6][7][8]. When pixel (r,c) is
//    accepted: win[0]=p(r-2,c-2), win[4]=p(r-1,c-1), win[8]=p(r,c).
//  - Reset values: window_out=0, window_valid=0, center_col=0, center_row=0,
//    col counter=0, row counter=0. Line-buffer RAM is not reset; the row gating below
//    masks its stale contents.
//  - Accept cycle (pixel_valid=1):
//    - Read lb0[col] (line r-1) and lb1[col] (line r-2).
//    - Write lb1[col] <= old lb0[col] and lb0[col] <= pixel_in.
//    - Shift the 3x3 register one column left and load the new column {lb1, lb0, pixel_in}.
//    - The read returns the old contents at the write address (read-before-write).
//  - Counters: col increments per accepted pixel. At col=IMG_WIDTH-1, col wraps to 0 and
//    row increments. At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 with no idle cycle,
//    so back-to-back frames are supported.
//  - sof=1 with pixel_valid=1: the pixel is treated as (0,0) regardless of the counters
//    (mid-frame resync). sof without pixel_valid is ignored.
//  - Output latency is 1 cycle. window_valid is registered high the cycle after accepting
//    (r,c) with r>=2 and c>=2; otherwise it is low. This gives exactly
//    (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame. No border padding; border pixels
//    produce no window.
//  - Reported centre: center_col=c-1, center_row=r-1, registered with window_out.
//  - Line wrap: the shift register carries columns across the line boundary. These
//    windows are suppressed by the c>=2 gating and must never be flagged valid.
//  - Stall (pixel_valid=0): counters, RAM and shift register hold; window_valid=0;
//    window_out holds its last value.
//  - Reset mid-frame: all counters return to 0. The next accepted pixel is (0,0) whether
//    or not sof is asserted. No window is emitted until two new lines have been filled.
//  - No backpressure input: the downstream stage is combinational and always ready.
//  - Counter widths: $clog2 of IMG_WIDTH / IMG_HEIGHT internally; zero-extended to
//    16 bits on the outputs.
// STRUCTURE
//  - Shared header vision_params.vh holds:
//    - default inputWidth, IMG_WIDTH, IMG_HEIGHT
//    - localparam WIN_TAPS=9 and the window tap indices (WIN_TL..WIN_BR)
//  - One sub-module, line_buffer: depth IMG_WIDTH, width inputWidth, single address,
//    read-before-write, write enable = pixel_valid. Instantiated twice (lb0, lb1).
//  - The top level holds the counters, the 3x3 shift register and the output registers.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=4, inputWidth=8, p(r,c)=16*r+c)
//  1. Full frame, pixel_valid held high, sof on the first pixel -> exactly 4 window_valid
//     pulses. The first comes one cycle after p(2,2) with win[0..8] =
//     00,01,02,10,11,12,20,21,22 and centre (1,1). The last has centre (2,2) and win[8]=0x33.
//  2. Same frame with pixel_valid toggling 1,0,0,1,... -> identical 4 windows in the same
//     order; window_valid is never high on a stall-following cycle without a new accept.
//  3. Two frames back-to-back, frame 2 pixels = p+0x80 -> 8 windows total. The first
//     frame-2 window has win[4]=0x91. No window straddles the frame boundary.
//  4. sof asserted at frame position (1,3) -> that pixel becomes (0,0). The next window
//     appears only after 2 lines plus 3 pixels of the new frame.
//  5. rst asserted for 1 cycle after p(2,3) -> all outputs 0 the next cycle. Then a fresh
//     frame without sof yields the 4 correct windows of test 1.
//  6. Line wrap check: monitor confirms no window_valid after accepting any pixel with
//     col<2 or row<2 across all tests.

Source files
------------

// File: rtl/window_3x3_gen_pkg.sv
// Shared vision-pipeline parameters: default pixel/frame geometry and 3x3 window tap indices.
package window_3x3_gen_pkg;
  localparam int DEF_INPUT_WIDTH = 8;
  localparam int DEF_IMG_WIDTH   = 640;
  localparam int DEF_IMG_HEIGHT  = 480;

  localparam int WIN_TAPS = 9;
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port line store: asynchronous read of the addressed entry, write on the clock edge,
// so a same-address access returns the previous line's pixel.
module line_buffer
  import window_3x3_gen_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_WIDTH,
  parameter int DATA_W = DEF_INPUT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wr_data_i;
  end
endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift register,
// and a window is flagged only for pixels with row>=2 and col>=2.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int inputWidth = DEF_INPUT_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [inputWidth-1:0]          pixel_in,
  input  logic                           pixel_valid,
  input  logic                           sof,
  output logic [WIN_TAPS*inputWidth-1:0] window_out,
  output logic                           window_valid,
  output logic [15:0]                    center_col,
  output logic [15:0]                    center_row
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         col_q, col_d, cur_col;
  logic [RW-1:0]         row_q, row_d, cur_row;
  logic [inputWidth-1:0] lb0_rd, lb1_rd;
  logic [inputWidth-1:0] win_q [WIN_TAPS];
  logic [inputWidth-1:0] win_d [WIN_TAPS];
  logic                  emit;
  logic                  vld_q;
  logic [15:0]           ccol_q, crow_q;

  // lb0 holds line r-1; lb1 receives lb0's old entry so it holds line r-2
  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(inputWidth)) u_lb0 (
    .clk_i     (clk),
    .we_i      (pixel_valid),
    .addr_i    (cur_col),
    .wr_data_i (pixel_in),
    .rd_data_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(inputWidth)) u_lb1 (
    .clk_i     (clk),
    .we_i      (pixel_valid),
    .addr_i    (cur_col),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    emit    = 1'b0;
    if (pixel_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      emit = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
      win_d[WIN_TL] = win_q[WIN_TC];
      win_d[WIN_TC] = win_q[WIN_TR];
      win_d[WIN_TR] = lb1_rd;
      win_d[WIN_ML] = win_q[WIN_MC];
      win_d[WIN_MC] = win_q[WIN_MR];
      win_d[WIN_MR] = lb0_rd;
      win_d[WIN_BL] = win_q[WIN_BC];
      win_d[WIN_BC] = win_q[WIN_BR];
      win_d[WIN_BR] = pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      ccol_q <= '0;
      crow_q <= '0;
      for (int i = 0; i < WIN_TAPS; i++) win_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= emit;
      win_q <= win_d;
      // Centre is only meaningful for emitted windows, so it tracks those alone
      if (emit) begin
        ccol_q <= 16'(cur_col - CW'(1));
        crow_q <= 16'(cur_row - RW'(1));
      end
    end
  end

  for (genvar g = 0; g < WIN_TAPS; g++) begin : g_pack
    assign window_out[g*inputWidth +: inputWidth] = win_q[g];
  end

  assign window_valid = vld_q;
  assign center_col   = ccol_q;
  assign center_row   = crow_q;
endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x4 frame: a frame-array model pushes expected
// windows, a negedge monitor pops and compares each window_valid pulse.
module tb_window_3x3_gen;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int WB = 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          sof = 1'b0;
  logic [WB-1:0] window_out;
  logic          window_valid;
  logic [15:0]   center_col, center_row;

  window_3x3_gen #(.inputWidth(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .sof          (sof),
    .window_out   (window_out),
    .window_valid (window_valid),
    .center_col   (center_col),
    .center_row   (center_row)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] win;
    logic [15:0]   ccol;
    logic [15:0]   crow;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  int            win_cnt = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] img [IH][IW];
  int            mr = 0;
  int            mc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (window_valid === 1'b1) begin
        win_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_window actual=valid(center r%0d c%0d) required=no_window",
                   center_row, center_col);
        end else begin
          e = exp_q.pop_front();
          check("window", window_out, e.win);
          check("center_col", center_col, e.ccol);
          check("center_row", center_row, e.crow);
        end
      end
    end
  end

  // One cycle of stimulus; the model assigns the frame position and predicts any window.
  task automatic send(input logic [DW-1:0] pix, input logic s, input logic v);
    logic [WB-1:0] prev_win;
    exp_t e;
    int r, c;
    pixel_in    = pix;
    sof         = s;
    pixel_valid = v;
    prev_win    = window_out;
    if (v) begin
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 9; i++) e.win[i*DW +: DW] = img[r-2+i/3][c-2+i%3];
        e.ccol = 16'(c - 1);
        e.crow = 16'(r - 1);
        exp_q.push_back(e);
      end
      mr = r;
      mc = c + 1;
      if (mc == IW) begin
        mc = 0;
        mr = (r + 1 == IH) ? 0 : r + 1;
      end
    end
    @(posedge clk);
    #1;
    if (!v) begin
      check("stall_valid", window_valid, 1'b0);
      check("stall_hold", window_out, prev_win);
    end
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  // mode 0: no stalls, 1: two stall cycles after every pixel, 2: random stalls/pixels/resync
  task automatic send_pixels(input int n, input int offset, input logic first_sof, input int mode);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] pix;
      logic          s;
      pix = (mode == 2) ? DW'($urandom_range(0, 255)) : DW'(offset + 16 * (k / IW) + (k % IW));
      s   = (k == 0) ? first_sof : 1'b0;
      if (mode == 2 && $urandom_range(0, 39) == 0) s = 1'b1;
      send(pix, s, 1'b1);
      if (mode == 1) begin
        send(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        send(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (mode == 2) begin
        for (int j = $urandom_range(0, 2); j > 0; j--)
          send(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_window_out", window_out, '0);
    check("rst_window_valid", window_valid, 1'b0);
    check("rst_center_col", center_col, 16'd0);
    check("rst_center_row", center_row, 16'd0);
    mr = 0;
    mc = 0;
  endtask

  task automatic finish_test(input string name, input int base, input int want);
    send('0, 1'b0, 1'b0);
    send('0, 1'b0, 1'b0);
    check({name, "_count"}, 128'(win_cnt - base), 128'(want));
    check({name, "_pending"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int base;
    do_reset();

    base = win_cnt;
    send_pixels(IW * IH, 0, 1'b1, 0);
    finish_test("t1_full_frame", base, 4);

    base = win_cnt;
    send_pixels(IW * IH, 0, 1'b1, 1);
    finish_test("t2_stall_frame", base, 4);

    base = win_cnt;
    send_pixels(IW * IH, 0, 1'b1, 0);
    send_pixels(IW * IH, 8'h80, 1'b0, 0);
    finish_test("t3_back_to_back", base, 8);

    base = win_cnt;
    send_pixels(7, 0, 1'b1, 0);
    send_pixels(IW * IH, 8'h40, 1'b1, 0);
    finish_test("t4_sof_resync", base, 4);

    base = win_cnt;
    send_pixels(12, 0, 1'b1, 0);
    finish_test("t5_partial", base, 2);
    do_reset();
    base = win_cnt;
    send_pixels(IW * IH, 0, 1'b0, 0);
    finish_test("t5_after_reset", base, 4);

    for (int f = 0; f < 4; f++) begin
      send_pixels(IW * IH, 0, 1'($urandom_range(0, 1)), 2);
    end
    send('0, 1'b0, 1'b0);
    send('0, 1'b0, 1'b0);
    check("rand_pending", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
